prefetch_queue: RTL

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues in-order fetches, pairs responses
// with their PCs and buffers them for decode; redirects flush in-flight work.
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t          state, state_nx;
  logic [31:0]     fetch_pc;
  logic [31:0]     fifo_pc   [DEPTH];
  logic [31:0]     fifo_inst [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, outstanding, drop;
  logic [CW-1:0]   out_nx, drop_nx;
  logic [CW:0]     inflight;
  logic [31:0]     tag_q [MAX_OUT];
  logic [TW-1:0]   tag_rd, tag_wr;
  logic            req_acc, push, pop;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_acc  = imem_req & imem_gnt;
  assign push     = imem_rvalid & ~redirect & (drop == '0);
  assign pop      = out_valid & out_ready & ~redirect;
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign out_nx   = outstanding + CW'(req_acc) - CW'(imem_rvalid);

  // A redirect turns everything still in flight into responses to discard
  always_comb begin
    drop_nx = drop;
    if (redirect)
      drop_nx = out_nx;
    else if (imem_rvalid && drop != '0)
      drop_nx = drop - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect)
      state_nx = (drop_nx != '0) ? FLUSH : FETCH;
    else if (state == FLUSH && drop_nx == '0)
      state_nx = FETCH;
  end

  always_comb begin
    imem_req  = rst && state == FETCH
             && outstanding < CW'(MAX_OUT)
             && inflight < (CW + 1)'(DEPTH);
    imem_addr = fetch_pc;
    out_valid = rst && count != '0;
    out_pc    = fifo_pc[rd_ptr];
    out_inst  = fifo_inst[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      outstanding <= out_nx;
      drop        <= drop_nx;
      if (redirect) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        tag_rd   <= '0;
        tag_wr   <= '0;
      end else begin
        if (req_acc) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wr   <= tag_inc(tag_wr);
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          tag_rd <= tag_inc(tag_rd);
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !redirect && req_acc)
      tag_q[tag_wr] <= fetch_pc;
    if (rst && push) begin
      fifo_pc[wr_ptr]   <= tag_q[tag_rd];
      fifo_inst[wr_ptr] <= imem_rdata;
    end
  end

  a_no_orphan_rvalid: assert property (
    @(posedge clk) disable iff (!rst) imem_rvalid |-> outstanding != '0
  );

endmodule
